at93c46_cmd_decoder: RTL and testbench
======================================

Name: at93c46_cmd_decoder

Overview:
- Upstream stage of the M24C08 write path. Acts as an AT93C46 (x8 organisation, 128 bytes) Microwire slave toward the SiTCP EEPROM port.
- Keeps a 128x8 shadow RAM that services READ locally with no I2C traffic.
- Turns WRITE/ERASE into single ROM write strobes (ROM_WE/ROM_CLK/ROM_ADDR/ROM_DATA) for the downstream M24 writer's buffer.
- A boot loader fills the shadow RAM through the LOAD port.

Parameters:
SYNC_STAGES, 2, synchronizer depth on CS/SK/DI; legal values 2..3

Ports:
SYSCLK_IN  in  1  system clock; all logic on rising edge
RESET_N_IN  in  1  asynchronous, active-low reset
EEPROM_CS_IN  in  1  Microwire chip select, active high, asynchronous to SYSCLK
EEPROM_SK_IN  in  1  Microwire serial clock, asynchronous; at least 4 SYSCLK per phase
EEPROM_DI_IN  in  1  Microwire serial data in
EEPROM_DO_OUT  out  1  Microwire serial data out
LOAD_WE_IN  in  1  shadow RAM write strobe from boot loader
LOAD_ADDR_IN  in  7  boot loader address
LOAD_DATA_IN  in  8  boot loader data
ROM_WE_OUT  out  1  one-cycle write strobe to writer buffer
ROM_CLK_OUT  out  1  one-cycle pulse, cycle after ROM_WE_OUT (advances writer pointer)
ROM_ADDR_OUT  out  7  write address; held until next write
ROM_DATA_OUT  out  8  write data; held until next write

Behaviour:
- Reset values: ROM_WE_OUT=0, ROM_CLK_OUT=0, ROM_ADDR_OUT=0, ROM_DATA_OUT=0, EEPROM_DO_OUT=1, state IDLE, EWEN latch=0. Shadow RAM has no reset.
- CS, SK and DI each pass through a SYNC_STAGES flop chain.
- SKR is an SK rising edge, detected on the synchronized SK. All sampling and shifting happen only on SKR while synchronized CS=1.
- Synchronized CS=0 at any time: go to IDLE, clear bit counter and shift registers, EEPROM_DO_OUT=1. No write is issued for a partial frame.
- IDLE: SKR with DI=1 is the start bit, go to CMD. SKR with DI=0 is ignored.
- CMD: shift in 9 bits MSB first, op[1:0] then addr[6:0]. Decode on the 9th SKR:
  - op=10 READ: go to RDATA. Read shadow[addr] (1-cycle RAM latency). DO=0 (dummy bit) in the same cycle.
  - op=01 WRITE: go to WDATA.
  - op=11 ERASE: data=0xFF, go to WRSTB.
  - op=00 with addr[6:5]=11 EWEN: latch=1, go to DONE.
  - op=00 with addr[6:5]=00 EWDS: latch=0, go to DONE.
  - op=00 with addr[6:5]=10 (ERAL) or 01 (WRAL): unsupported. WRAL data bits are ignored. Go to DONE, no write.
- RDATA: each SKR drives the next data bit on DO, MSB first. After bit 0, address wraps 127 to 0 and reading continues with the next byte for as long as CS stays high.
- WDATA: shift in 8 data bits. On the 8th SKR, go to WRSTB.
- WRSTB (one cycle):
  - If latch=1: write shadow[addr]=data, drive ROM_ADDR_OUT/ROM_DATA_OUT, ROM_WE_OUT=1.
  - Next cycle: ROM_WE_OUT=0, ROM_CLK_OUT=1. The cycle after that: ROM_CLK_OUT=0.
  - If latch=0: no RAM write, no strobes.
  - Go to DONE in all cases.
- DONE: DO=1 (ready; the write is buffered so it never shows busy). Further SKR are ignored until CS=0.
- LOAD_WE_IN=1 writes shadow[LOAD_ADDR_IN]=LOAD_DATA_IN and produces no ROM strobe.
- LOAD collides with a WRSTB RAM write in the same cycle: the WRSTB write wins and the load is dropped. The loader runs only while CS=0.
- Consecutive WRITE frames: ROM strobes are separated by at least one full frame. The writer sees at most one WE per ROM_CLK.
- Reset asserted mid-operation: immediate return to reset values, and any pending ROM_CLK pulse is cancelled. A ROM_WE already issued in an earlier cycle is not retracted.

Test Plan:
- Reset, LOAD addr 0x05=0xA5. Frame CS=1: start, 10, 0000101 -> DO shows 0 then 1,0,1,0,0,1,0,1. No ROM_WE.
- EWEN (start, 00, 11xxxxx), then WRITE addr 0x7F data 0x3C -> exactly one ROM_WE with ROM_ADDR_OUT=0x7F and ROM_DATA_OUT=0x3C, ROM_CLK_OUT next cycle. A following READ 0x7F returns 0x3C.
- EWDS, then WRITE 0x10=0x55 -> no ROM_WE/ROM_CLK. READ 0x10 returns the prior value.
- With EWEN: ERASE 0x20 -> ROM_WE with data 0xFF. READ starting at 0x7F, held for 16 bits -> bytes shadow[0x7F], then shadow[0x00] (wrap).
- CS dropped after 4 WRITE data bits -> no strobe and state IDLE. The next full READ decodes correctly.
- ERAL/WRAL frames with EWEN set -> no strobes and shadow unchanged.
- Reset asserted in the WRSTB cycle -> outputs return to reset values and ROM_CLK_OUT stays 0.

Source files
------------

// File: rtl/at93c46_cmd_decoder.sv
// AT93C46 (x8, 128 bytes) Microwire slave: serves READ from a local shadow RAM
// and turns enabled WRITE/ERASE frames into single ROM write strobes.
module at93c46_cmd_decoder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       SYSCLK_IN,
  input  logic       RESET_N_IN,
  input  logic       EEPROM_CS_IN,
  input  logic       EEPROM_SK_IN,
  input  logic       EEPROM_DI_IN,
  output logic       EEPROM_DO_OUT,
  input  logic       LOAD_WE_IN,
  input  logic [6:0] LOAD_ADDR_IN,
  input  logic [7:0] LOAD_DATA_IN,
  output logic       ROM_WE_OUT,
  output logic       ROM_CLK_OUT,
  output logic [6:0] ROM_ADDR_OUT,
  output logic [7:0] ROM_DATA_OUT
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_RDATA = 3'd2;
  localparam logic [2:0] ST_WDATA = 3'd3;
  localparam logic [2:0] ST_WRSTB = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sk_sync_q, sk_sync_d;
  logic [SYNC_STAGES-1:0] di_sync_q, di_sync_d;
  logic                   sk_prev_q, sk_prev_d;
  logic [2:0]             state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [6:0]             addr_q, addr_d;
  logic [7:0]             data_q, data_d;
  logic                   ewen_q, ewen_d;
  logic                   do_q, do_d;
  logic                   rom_we_q, rom_we_d;
  logic                   rom_clk_q, rom_clk_d;
  logic [6:0]             rom_addr_q, rom_addr_d;
  logic [7:0]             rom_data_q, rom_data_d;

  logic [7:0]             shadow_mem [128];
  logic [7:0]             rd_data_q, rd_data_d;
  logic                   ram_we;
  logic [6:0]             ram_waddr;
  logic [7:0]             ram_wdata;

  logic                   cs_s, sk_s, di_s, skr;
  logic [8:0]             full_cmd;
  logic [1:0]             dec_op;
  logic [6:0]             dec_addr;
  logic [7:0]             wr_byte;

  assign cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], EEPROM_CS_IN};
  assign sk_sync_d = {sk_sync_q[SYNC_STAGES-2:0], EEPROM_SK_IN};
  assign di_sync_d = {di_sync_q[SYNC_STAGES-2:0], EEPROM_DI_IN};

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sk_s     = sk_sync_q[SYNC_STAGES-1];
  assign di_s     = di_sync_q[SYNC_STAGES-1];
  assign skr      = sk_s & ~sk_prev_q;
  // The 9th command bit is still on DI when the frame is decoded.
  assign full_cmd = {cmd_q, di_s};
  assign dec_op   = full_cmd[8:7];
  assign dec_addr = full_cmd[6:0];
  assign wr_byte  = {data_q[6:0], di_s};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    ewen_d     = ewen_q;
    do_d       = do_q;
    rom_we_d   = 1'b0;
    rom_clk_d  = rom_we_q;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
    sk_prev_d  = sk_s;
    if (!cs_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      cmd_d     = 8'd0;
      data_d    = 8'd0;
      do_d      = 1'b1;
    end else if (state_q == ST_WRSTB) begin
      state_d = ST_DONE;
      do_d    = 1'b1;
    end else if (skr) begin
      case (state_q)
        ST_IDLE: begin
          if (di_s) begin
            state_d   = ST_CMD;
            bit_cnt_d = 4'd0;
          end
        end
        ST_CMD: begin
          cmd_d     = full_cmd[7:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            addr_d    = dec_addr;
            case (dec_op)
              2'b10: begin
                state_d = ST_RDATA;
                do_d    = 1'b0;
              end
              2'b01: state_d = ST_WDATA;
              2'b11: begin
                data_d  = 8'hFF;
                state_d = ST_WRSTB;
                if (ewen_q) begin
                  rom_we_d   = 1'b1;
                  rom_addr_d = dec_addr;
                  rom_data_d = 8'hFF;
                end
              end
              default: begin
                state_d = ST_DONE;
                if (dec_addr[6:5] == 2'b11) ewen_d = 1'b1;
                else if (dec_addr[6:5] == 2'b00) ewen_d = 1'b0;
              end
            endcase
          end
        end
        ST_RDATA: begin
          // MSB first: bit index is 7 - count.
          do_d      = rd_data_q[~bit_cnt_q[2:0]];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            addr_d    = addr_q + 7'd1;
          end
        end
        ST_WDATA: begin
          data_d    = wr_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            state_d   = ST_WRSTB;
            if (ewen_q) begin
              rom_we_d   = 1'b1;
              rom_addr_d = addr_q;
              rom_data_d = wr_byte;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A strobe write in WRSTB takes priority over the boot loader.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = LOAD_ADDR_IN;
    ram_wdata = LOAD_DATA_IN;
    if (state_q == ST_WRSTB && ewen_q) begin
      ram_we    = 1'b1;
      ram_waddr = addr_q;
      ram_wdata = data_q;
    end else if (LOAD_WE_IN) begin
      ram_we = 1'b1;
    end
  end

  assign rd_data_d = shadow_mem[addr_q];

  always_ff @(posedge SYSCLK_IN) begin
    if (ram_we) shadow_mem[ram_waddr] <= ram_wdata;
    rd_data_q <= rd_data_d;
  end

  always_ff @(posedge SYSCLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      cs_sync_q  <= '0;
      sk_sync_q  <= '0;
      di_sync_q  <= '0;
      sk_prev_q  <= 1'b0;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      cmd_q      <= 8'd0;
      addr_q     <= 7'd0;
      data_q     <= 8'd0;
      ewen_q     <= 1'b0;
      do_q       <= 1'b1;
      rom_we_q   <= 1'b0;
      rom_clk_q  <= 1'b0;
      rom_addr_q <= 7'd0;
      rom_data_q <= 8'd0;
    end else begin
      cs_sync_q  <= cs_sync_d;
      sk_sync_q  <= sk_sync_d;
      di_sync_q  <= di_sync_d;
      sk_prev_q  <= sk_prev_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ewen_q     <= ewen_d;
      do_q       <= do_d;
      rom_we_q   <= rom_we_d;
      rom_clk_q  <= rom_clk_d;
      rom_addr_q <= rom_addr_d;
      rom_data_q <= rom_data_d;
    end
  end

  assign EEPROM_DO_OUT = do_q;
  assign ROM_WE_OUT    = rom_we_q;
  assign ROM_CLK_OUT   = rom_clk_q;
  assign ROM_ADDR_OUT  = rom_addr_q;
  assign ROM_DATA_OUT  = rom_data_q;

endmodule

// File: tb/tb_at93c46_cmd_decoder.sv
// Bench for at93c46_cmd_decoder: Microwire frames driven bit by bit, checked
// against a byte-array model of the shadow RAM and a queue of expected ROM writes.
module tb_at93c46_cmd_decoder;

  logic       SYSCLK_IN;
  logic       RESET_N_IN;
  logic       EEPROM_CS_IN;
  logic       EEPROM_SK_IN;
  logic       EEPROM_DI_IN;
  logic       EEPROM_DO_OUT;
  logic       LOAD_WE_IN;
  logic [6:0] LOAD_ADDR_IN;
  logic [7:0] LOAD_DATA_IN;
  logic       ROM_WE_OUT;
  logic       ROM_CLK_OUT;
  logic [6:0] ROM_ADDR_OUT;
  logic [7:0] ROM_DATA_OUT;

  at93c46_cmd_decoder #(.SYNC_STAGES(2)) dut (
    .SYSCLK_IN     (SYSCLK_IN),
    .RESET_N_IN    (RESET_N_IN),
    .EEPROM_CS_IN  (EEPROM_CS_IN),
    .EEPROM_SK_IN  (EEPROM_SK_IN),
    .EEPROM_DI_IN  (EEPROM_DI_IN),
    .EEPROM_DO_OUT (EEPROM_DO_OUT),
    .LOAD_WE_IN    (LOAD_WE_IN),
    .LOAD_ADDR_IN  (LOAD_ADDR_IN),
    .LOAD_DATA_IN  (LOAD_DATA_IN),
    .ROM_WE_OUT    (ROM_WE_OUT),
    .ROM_CLK_OUT   (ROM_CLK_OUT),
    .ROM_ADDR_OUT  (ROM_ADDR_OUT),
    .ROM_DATA_OUT  (ROM_DATA_OUT)
  );

  // Clock / reset
  initial SYSCLK_IN = 1'b0;
  always #5 SYSCLK_IN = ~SYSCLK_IN;

  int errors = 0;
  int checks = 0;

  // Reference model: shadow contents, write-enable latch, expected ROM writes.
  logic [7:0]  model_mem [128];
  logic        model_ewen = 1'b0;
  logic [14:0] exp_q[$];
  logic        prev_we = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ROM strobe scoreboard: every WE must match the queue, CLK follows WE by one cycle.
  always @(negedge SYSCLK_IN) begin
    logic [14:0] e;
    if (ROM_WE_OUT === 1'b1) begin
      if (exp_q.size() == 0) chk("rom_we_unexpected", 32'(ROM_WE_OUT), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("rom_wr_addr_data", 32'({ROM_ADDR_OUT, ROM_DATA_OUT}), 32'(e));
      end
    end
    if (ROM_CLK_OUT === 1'b1 || prev_we) chk("rom_clk_after_we", 32'(ROM_CLK_OUT), 32'(prev_we));
    prev_we = (ROM_WE_OUT === 1'b1);
  end

  // Driver tasks
  task automatic load_byte(input logic [6:0] a, input logic [7:0] d);
    @(negedge SYSCLK_IN);
    LOAD_WE_IN = 1'b1; LOAD_ADDR_IN = a; LOAD_DATA_IN = d;
    @(negedge SYSCLK_IN);
    LOAD_WE_IN = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic load_all();
    for (int i = 0; i < 128; i++) load_byte(7'(i), 8'($urandom_range(0, 255)));
  endtask

  task automatic cs_on();
    @(negedge SYSCLK_IN);
    EEPROM_CS_IN = 1'b1;
    repeat (4) @(negedge SYSCLK_IN);
  endtask

  task automatic cs_off();
    @(negedge SYSCLK_IN);
    EEPROM_CS_IN = 1'b0; EEPROM_SK_IN = 1'b0; EEPROM_DI_IN = 1'b0;
    repeat (6) @(negedge SYSCLK_IN);
  endtask

  // One SK period: DI set while SK low, DO sampled late in the high phase.
  task automatic sk_bit(input logic b, output logic d);
    @(negedge SYSCLK_IN);
    EEPROM_DI_IN = b;
    repeat (4) @(negedge SYSCLK_IN);
    EEPROM_SK_IN = 1'b1;
    repeat (5) @(negedge SYSCLK_IN);
    d = EEPROM_DO_OUT;
    EEPROM_SK_IN = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [6:0] a, output logic d);
    sk_bit(1'b1, d);
    for (int i = 1; i >= 0; i--) sk_bit(op[i], d);
    for (int i = 6; i >= 0; i--) sk_bit(a[i], d);
  endtask

  task automatic do_read(input logic [6:0] a, input int nbytes);
    logic d;
    logic [7:0] b;
    cs_on();
    send_cmd(2'b10, a, d);
    chk("rd_dummy_bit", 32'(d), 32'd0);
    for (int k = 0; k < nbytes; k++) begin
      b = 8'd0;
      for (int i = 0; i < 8; i++) begin
        sk_bit(1'b0, d);
        b = {b[6:0], d};
      end
      chk($sformatf("rd_data@%0h", (int'(a) + k) % 128), 32'(b), 32'(model_mem[(int'(a) + k) % 128]));
    end
    cs_off();
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] dt);
    logic d;
    if (model_ewen) begin
      model_mem[a] = dt;
      exp_q.push_back({a, dt});
    end
    cs_on();
    send_cmd(2'b01, a, d);
    for (int i = 7; i >= 0; i--) sk_bit(dt[i], d);
    chk("wr_done_do", 32'(d), 32'd1);
    cs_off();
  endtask

  task automatic do_erase(input logic [6:0] a);
    logic d;
    if (model_ewen) begin
      model_mem[a] = 8'hFF;
      exp_q.push_back({a, 8'hFF});
    end
    cs_on();
    send_cmd(2'b11, a, d);
    sk_bit(1'b0, d);
    chk("erase_done_do", 32'(d), 32'd1);
    cs_off();
  endtask

  // op=00 frames; sel is addr[6:5]: 11 EWEN, 00 EWDS, 10 ERAL, 01 WRAL.
  task automatic do_special(input logic [1:0] sel);
    logic d;
    cs_on();
    send_cmd(2'b00, {sel, 5'($urandom_range(0, 31))}, d);
    if (sel == 2'b01) for (int i = 0; i < 8; i++) sk_bit(1'($urandom_range(0, 1)), d);
    chk("special_do", 32'(d), 32'd1);
    cs_off();
    if (sel == 2'b11) model_ewen = 1'b1;
    if (sel == 2'b00) model_ewen = 1'b0;
  endtask

  task automatic do_partial_write(input logic [6:0] a);
    logic d;
    cs_on();
    send_cmd(2'b01, a, d);
    for (int i = 0; i < 4; i++) sk_bit(1'($urandom_range(0, 1)), d);
    cs_off();
  endtask

  initial begin
    logic d;
    logic [7:0] dt;
    RESET_N_IN = 1'b0;
    EEPROM_CS_IN = 1'b0; EEPROM_SK_IN = 1'b0; EEPROM_DI_IN = 1'b0;
    LOAD_WE_IN = 1'b0; LOAD_ADDR_IN = 7'd0; LOAD_DATA_IN = 8'd0;
    repeat (5) @(negedge SYSCLK_IN);
    chk("reset_we", 32'(ROM_WE_OUT), 32'd0);
    chk("reset_clk", 32'(ROM_CLK_OUT), 32'd0);
    chk("reset_addr", 32'(ROM_ADDR_OUT), 32'd0);
    chk("reset_data", 32'(ROM_DATA_OUT), 32'd0);
    chk("reset_do", 32'(EEPROM_DO_OUT), 32'd1);
    RESET_N_IN = 1'b1;
    repeat (3) @(negedge SYSCLK_IN);

    load_all();
    load_byte(7'h05, 8'hA5);
    do_read(7'h05, 1);

    do_special(2'b11);
    do_write(7'h7F, 8'h3C);
    do_read(7'h7F, 1);

    do_special(2'b00);
    do_write(7'h10, 8'h55);
    do_read(7'h10, 1);

    do_special(2'b11);
    do_erase(7'h20);
    do_read(7'h20, 1);
    do_read(7'h7F, 2);

    do_partial_write(7'h33);
    do_read(7'h33, 1);

    do_special(2'b10);
    do_special(2'b01);
    do_read(7'h00, 3);

    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 6))
        0: do_read(7'($urandom_range(0, 127)), $urandom_range(1, 3));
        1, 2: do_write(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
        3: do_erase(7'($urandom_range(0, 127)));
        4: do_special(2'b11);
        5: do_special(2'b00);
        default: do_partial_write(7'($urandom_range(0, 127)));
      endcase
    end

    // Reset landing in the strobe cycle: WE has gone out, CLK must never follow.
    do_special(2'b11);
    dt = 8'($urandom_range(0, 255));
    cs_on();
    send_cmd(2'b01, 7'h44, d);
    for (int i = 7; i >= 1; i--) sk_bit(dt[i], d);
    @(negedge SYSCLK_IN);
    EEPROM_DI_IN = dt[0];
    repeat (4) @(negedge SYSCLK_IN);
    EEPROM_SK_IN = 1'b1;
    repeat (3) @(posedge SYSCLK_IN);
    #1;
    chk("rst_mid_we_issued", 32'(ROM_WE_OUT), 32'd1);
    RESET_N_IN = 1'b0;
    #1;
    chk("rst_mid_we", 32'(ROM_WE_OUT), 32'd0);
    chk("rst_mid_addr", 32'(ROM_ADDR_OUT), 32'd0);
    chk("rst_mid_data", 32'(ROM_DATA_OUT), 32'd0);
    chk("rst_mid_do", 32'(EEPROM_DO_OUT), 32'd1);
    EEPROM_CS_IN = 1'b0; EEPROM_SK_IN = 1'b0; EEPROM_DI_IN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge SYSCLK_IN);
      chk("rst_mid_clk_low", 32'(ROM_CLK_OUT), 32'd0);
    end
    RESET_N_IN = 1'b1;
    model_ewen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge SYSCLK_IN);
      chk("post_rst_clk_low", 32'(ROM_CLK_OUT), 32'd0);
    end

    load_all();
    do_write(7'h44, 8'h99);
    do_read(7'h44, 2);

    repeat (10) @(negedge SYSCLK_IN);
    chk("rom_writes_outstanding", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
